// File: rtl/spi_ctrl_pkg.sv
// Shared types and frame helpers for the SPI register-write controller.
// Frame layout is {write bit, addr[6:0], data[7:0]}, transmitted MSB first.
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic WRITE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_write_controller_if.sv
// Request handshake plus SPI pins of the write controller.
// master = request issuer / pin observer, slave = the controller itself.
interface spi_write_controller_if;
  import spi_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              ncs;
  logic              sclk;
  logic              copi;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, ncs, sclk, copi, busy, done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, ncs, sclk, copi, busy, done
  );

endinterface

// File: rtl/spi_clk_tick.sv
// Emits a one-cycle tick every CLK_DIV clocks; counter held at zero while i_clr.
// Latency: first tick CLK_DIV cycles after i_clr drops; no backpressure.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last & ~i_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_write_controller.sv
// SPI mode-0 initiator turning one accepted register write into a 16-bit ncs/sclk/copi frame.
// Latency: ncs falls the cycle after accept, req_ready returns 36*CLK_DIV cycles later; requests are refused while busy.
module spi_write_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic                   clk,
  input logic                   rst,
  spi_write_controller_if.slave bus
);

  localparam logic [3:0] LAST_BIT = 4'd15;

  state_t               r_state;
  logic [FRAME_W-2:0]   r_shift;
  logic [3:0]           r_bit;
  logic                 r_ncs;
  logic                 r_sclk;
  logic                 r_copi;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_tick;
  logic                 w_clr;

  assign w_frame = build_frame(bus.req_addr, bus.req_data);
  assign w_clr   = (r_state == IDLE);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_shift <= w_frame[FRAME_W-2:0];
            r_copi  <= w_frame[FRAME_W-1];
            r_bit   <= '0;
            r_ncs   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            // copi moves on the falling edge; the last bit is held through its low phase
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (r_bit != LAST_BIT) begin
                r_copi  <= r_shift[FRAME_W-2];
                r_shift <= {r_shift[FRAME_W-3:0], 1'b0};
              end
            end else if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_state <= HOLD;
            end else begin
              r_sclk <= 1'b1;
              r_bit  <= r_bit + 4'd1;
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_ncs   <= 1'b1;
            r_copi  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= GAP;
          end
        end
        GAP: begin
          // two divider periods of deselect; r_bit[0] marks the first one as spent
          if (w_tick) begin
            if (r_bit[0]) begin
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_bit <= 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.ncs       = r_ncs;
  assign bus.sclk      = r_sclk;
  assign bus.copi      = r_copi;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_spi_write_controller.sv
// Bench for spi_write_controller: a CLK_DIV=4 instance and a CLK_DIV=1 instance feeding a behavioural SPI peripheral.
module tb_spi_write_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_write_controller_if if4 ();
  spi_write_controller_if if1 ();

  spi_write_controller #(.CLK_DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  spi_write_controller #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    int          t;
    logic [15:0] cap;
    int          rises;
    int          low;
    int          first_hi;
    int          done_off;
    int          ready_off;
    int          gaphi;
  } frame_rec_t;

  typedef struct {
    int          dut;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;

  frame_rec_t q0[$];
  frame_rec_t q1[$];
  frame_rec_t cur[2];
  int   act[2];
  int   acc_cnt[2];
  int   done_cnt[2];
  int   comp_cnt[2];
  logic p_rdy[2];
  logic p_sclk[2];
  logic p_ncs1;
  int   viol = 0;
  int   busyviol = 0;
  logic [15:0] psh;
  int   pbits;
  logic [7:0]  preg [128];
  vec_t vec [7];

  logic [1:0] m_ncs, m_sclk, m_copi, m_rdy, m_busy, m_done;
  assign m_ncs  = {if1.ncs, if4.ncs};
  assign m_sclk = {if1.sclk, if4.sclk};
  assign m_copi = {if1.copi, if4.copi};
  assign m_rdy  = {if1.req_ready, if4.req_ready};
  assign m_busy = {if1.busy, if4.busy};
  assign m_done = {if1.done, if4.done};

  // Pin-level observer: reconstructs each frame and its timing from the SPI pins alone.
  always @(negedge clk) begin
    if (rst) begin
      pbits = 0;
    end else begin
      if (p_ncs1 && !if1.ncs) pbits = 0;
      if (!if1.ncs && if1.sclk && !p_sclk[1]) begin
        psh = {psh[14:0], if1.copi};
        pbits++;
      end
      if (!p_ncs1 && if1.ncs && pbits == 16 && psh[15]) preg[psh[14:8]] = psh[7:0];
    end
    p_ncs1 = if1.ncs;

    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 0;
      end else begin
        if (p_rdy[i] && !m_rdy[i]) begin
          acc_cnt[i]++;
          act[i]           = 1;
          cur[i].t         = cyc;
          cur[i].cap       = '0;
          cur[i].rises     = 0;
          cur[i].low       = 0;
          cur[i].first_hi  = -1;
          cur[i].done_off  = -1;
          cur[i].ready_off = -1;
          cur[i].gaphi     = 0;
        end
        if (act[i] != 0) begin
          if (!m_ncs[i]) cur[i].low++;
          if (m_sclk[i] && !p_sclk[i]) begin
            cur[i].rises++;
            cur[i].cap = {cur[i].cap[14:0], m_copi[i]};
          end
          if (m_sclk[i] && cur[i].first_hi < 0) cur[i].first_hi = cyc - cur[i].t;
          if (m_done[i]) cur[i].done_off = cyc - cur[i].t;
          if (m_ncs[i] && m_busy[i]) cur[i].gaphi++;
          if (m_rdy[i]) begin
            cur[i].ready_off = cyc - cur[i].t;
            if (i == 0) q0.push_back(cur[i]);
            else q1.push_back(cur[i]);
            comp_cnt[i]++;
            act[i] = 0;
          end
        end
      end
      if (m_done[i]) done_cnt[i]++;
      if (m_sclk[i] && m_ncs[i]) viol++;
      if (m_busy[i] == m_rdy[i]) busyviol++;
      p_rdy[i]  = m_rdy[i];
      p_sclk[i] = m_sclk[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [6:0] a, input logic [7:0] x);
    if (d == 0) begin
      if4.req_valid = v; if4.req_addr = a; if4.req_data = x;
    end else begin
      if1.req_valid = v; if1.req_addr = a; if1.req_data = x;
    end
  endtask

  task automatic wait_acc(input int d, input int target);
    int k = 0;
    while (acc_cnt[d] < target && k < 400) begin
      tick();
      k++;
    end
    chk("accept_wait", 32'(acc_cnt[d] >= target), 1);
  endtask

  task automatic wait_frames(input int d, input int n);
    int k = 0;
    while (((d == 0) ? q0.size() : q1.size()) < n && k < 2000) begin
      tick();
      k++;
    end
    chk("frame_wait", 32'(((d == 0) ? q0.size() : q1.size()) >= n), 1);
  endtask

  task automatic write_one(input int d, input logic [6:0] a, input logic [7:0] x);
    int tgt;
    tgt = acc_cnt[d] + 1;
    drive(d, 1'b1, a, x);
    wait_acc(d, tgt);
    drive(d, 1'b0, a, x);
  endtask

  // Expected timing: SETUP D, 16 bits of 2D, HOLD D, GAP 2D.
  task automatic check_frame(input int d, input logic [15:0] exp, input string name, output int t_out);
    frame_rec_t r;
    int dv;
    dv = (d == 0) ? 4 : 1;
    t_out = 0;
    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      r = (d == 0) ? q0.pop_front() : q1.pop_front();
      t_out = r.t;
      chk({name, "_frame"}, 32'(r.cap), 32'(exp));
      chk({name, "_rises"}, r.rises, 16);
      chk({name, "_ncs_low"}, r.low, 34 * dv);
      chk({name, "_first_rise"}, r.first_hi, dv);
      chk({name, "_done_at"}, r.done_off, 34 * dv);
      chk({name, "_ready_at"}, r.ready_off, 36 * dv);
      chk({name, "_gap"}, r.gaphi, 2 * dv);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, base, dn, k, d;
    logic [6:0] ra;
    logic [7:0] rx;
    logic [7:0] exp_uo;

    for (int i = 0; i < 2; i++) begin
      act[i] = 0; acc_cnt[i] = 0; done_cnt[i] = 0; comp_cnt[i] = 0;
      p_rdy[i] = 1'b1; p_sclk[i] = 1'b0;
    end
    for (int i = 0; i < 128; i++) preg[i] = 8'h00;
    p_ncs1 = 1'b1; psh = '0; pbits = 0;
    exp_uo = 8'h00;

    vec[0] = '{dut: 0, addr: 7'h00, data: 8'hF0, exp: 16'h80F0};
    vec[1] = '{dut: 0, addr: 7'h01, data: 8'hFF, exp: 16'h81FF};
    vec[2] = '{dut: 0, addr: 7'h02, data: 8'h5A, exp: 16'h825A};
    vec[3] = '{dut: 0, addr: 7'h03, data: 8'h3C, exp: 16'h833C};
    vec[4] = '{dut: 0, addr: 7'h7F, data: 8'h00, exp: 16'hFF00};
    vec[5] = '{dut: 1, addr: 7'h55, data: 8'hAA, exp: 16'hD5AA};
    vec[6] = '{dut: 1, addr: 7'h00, data: 8'hA5, exp: 16'h80A5};

    // Reset held with a request pending
    rst = 1'b1;
    drive(0, 1'b1, vec[0].addr, vec[0].data);
    drive(1, 1'b0, 7'h00, 8'h00);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_ncs", if4.ncs, 1);
      chk("rst_sclk", if4.sclk, 0);
      chk("rst_copi", if4.copi, 0);
      chk("rst_ready", if4.req_ready, 1);
      chk("rst_busy", if4.busy, 0);
      chk("rst_d1_ncs", if1.ncs, 1);
    end
    rst = 1'b0;
    tick();
    chk("first_edge_accept_ready", if4.req_ready, 0);
    chk("first_edge_accept_ncs", if4.ncs, 0);
    drive(0, 1'b0, vec[0].addr, vec[0].data);
    wait_frames(0, 1);
    check_frame(0, vec[0].exp, "w00", t1);
    chk("w00_done_count", done_cnt[0], 1);

    // Back-to-back with req_valid held high
    tick();
    base = acc_cnt[0];
    drive(0, 1'b1, vec[1].addr, vec[1].data);
    wait_acc(0, base + 1);
    drive(0, 1'b1, vec[2].addr, vec[2].data);
    wait_acc(0, base + 2);
    drive(0, 1'b0, vec[2].addr, vec[2].data);
    wait_frames(0, 2);
    check_frame(0, vec[1].exp, "b2b_a", t1);
    check_frame(0, vec[2].exp, "b2b_b", t2);
    chk("b2b_period", t2 - t1, 36 * 4 + 1);
    chk("b2b_done_count", done_cnt[0], 3);

    // Inputs disturbed and req_valid pulsed mid-frame
    base = acc_cnt[0];
    write_one(0, 7'h10, 8'h33);
    repeat (20) tick();
    drive(0, 1'b1, 7'h7F, 8'hFF);
    repeat (3) tick();
    drive(0, 1'b0, 7'h7F, 8'hFF);
    wait_frames(0, 1);
    check_frame(0, 16'h9033, "midchg", t1);
    repeat (20) tick();
    chk("midchg_no_extra_accept", acc_cnt[0], base + 1);

    // Reset after the 7th sclk rise
    dn = done_cnt[0];
    write_one(0, 7'h44, 8'h11);
    k = 0;
    while (cur[0].rises < 7 && k < 300) begin
      tick();
      k++;
    end
    chk("abort_reached_rise7", cur[0].rises, 7);
    rst = 1'b1;
    #1;
    chk("abort_ncs", if4.ncs, 1);
    chk("abort_sclk", if4.sclk, 0);
    chk("abort_copi", if4.copi, 0);
    chk("abort_ready", if4.req_ready, 1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("abort_no_done", done_cnt[0], dn);
    chk("abort_no_frame", q0.size(), 0);
    write_one(0, vec[3].addr, vec[3].data);
    wait_frames(0, 1);
    check_frame(0, vec[3].exp, "after_abort", t1);

    // Remaining table entries; the CLK_DIV=1 ones also load the peripheral model
    for (int v = 4; v < 7; v++) begin
      repeat (2) tick();
      write_one(vec[v].dut, vec[v].addr, vec[v].data);
      wait_frames(vec[v].dut, 1);
      check_frame(vec[v].dut, vec[v].exp, $sformatf("vec%0d", v), t1);
    end
    chk("periph_reg55", preg[7'h55], 8'hAA);
    chk("periph_uo_out", preg[0], 8'hA5);
    exp_uo = 8'hA5;

    // Randomised writes on both instances
    for (int r = 0; r < 12; r++) begin
      d  = r % 2;
      ra = 7'($urandom_range(0, 127));
      rx = 8'($urandom_range(0, 255));
      if (r == 11) ra = 7'h00;
      repeat ($urandom_range(0, 3)) tick();
      write_one(d, ra, rx);
      wait_frames(d, 1);
      check_frame(d, {1'b1, ra, rx}, $sformatf("rnd%0d", r), t1);
      if (d == 1) begin
        if (ra == 7'h00) exp_uo = rx;
        chk($sformatf("rnd%0d_periph", r), preg[ra], rx);
        chk($sformatf("rnd%0d_uo_out", r), preg[0], exp_uo);
      end
    end

    repeat (5) tick();
    chk("sclk_high_while_deselected", viol, 0);
    chk("busy_not_inverse_ready", busyviol, 0);
    chk("done_pulses_d4", done_cnt[0], comp_cnt[0]);
    chk("done_pulses_d1", done_cnt[1], comp_cnt[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
